// File: rtl/dual_issue_fetch_ctrl.sv
// Dual-issue fetch sequencer: drives PC/PC4 into a dual-read instruction memory,
// issues one or both returned instructions per cycle, and handles redirect, stall and halt.
module dual_issue_fetch_ctrl #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_en,
    input  logic [XLEN-1:0]  branch_pc,
    input  logic             stall,
    input  logic [31:0]      instr1,
    input  logic [31:0]      instr2,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PC4,
    output logic             slot0_valid,
    output logic [31:0]      slot0_instr,
    output logic [XLEN-1:0]  slot0_pc,
    output logic             slot1_valid,
    output logic [31:0]      slot1_instr,
    output logic [XLEN-1:0]  slot1_pc,
    output logic             halted,
    output logic             misalign,
    output logic [CNT_W-1:0] pair_cnt,
    output logic [CNT_W-1:0] single_cnt
);

    localparam logic [XLEN-1:0]  FOUR  = XLEN'(4);
    localparam logic [XLEN-1:0]  EIGHT = XLEN'(8);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic              slot0_valid_q, slot1_valid_q;
    logic [31:0]       slot0_instr_q, slot1_instr_q;
    logic [XLEN-1:0]   slot0_pc_q, slot1_pc_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  pair_cnt_q, single_cnt_q;

    logic              split_d;
    logic [XLEN-1:0]   redirect_pc_d;

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_ST) || (op == OP_BR);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Intra-pair hazard: anything that forces slot 1 to wait a cycle.
    always_comb begin
        logic [4:0] rd1;
        logic       dep;
        rd1     = instr1[11:7];
        dep     = ((instr2[6:0] != OP_JAL) && (instr2[19:15] == rd1)) ||
                  (reads_rs2(instr2[6:0]) && (instr2[24:20] == rd1)) ||
                  (writes_rd(instr2[6:0]) && (instr2[11:7] == rd1));
        split_d = (writes_rd(instr1[6:0]) && (rd1 != 5'd0) && dep) ||
                  (is_mem(instr1[6:0]) && is_mem(instr2[6:0])) ||
                  is_ctrl(instr1[6:0]) ||
                  (instr2 == 32'h0);
        redirect_pc_d = {branch_pc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
            slot0_instr_q <= '0;
            slot1_instr_q <= '0;
            slot0_pc_q    <= '0;
            slot1_pc_q    <= '0;
            misalign_q    <= 1'b0;
            pair_cnt_q    <= '0;
            single_cnt_q  <= '0;
        end else if (branch_en) begin
            state_q       <= ST_RUN;
            pc_q          <= redirect_pc_d;
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
            if (branch_pc[1:0] != 2'b00) misalign_q <= 1'b1;
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (instr1 == 32'h0) begin
                        state_q       <= ST_HALT;
                        slot0_valid_q <= 1'b0;
                        slot1_valid_q <= 1'b0;
                    end else begin
                        slot0_valid_q <= 1'b1;
                        slot0_instr_q <= instr1;
                        slot0_pc_q    <= pc_q;
                        if (!split_d) begin
                            slot1_valid_q <= 1'b1;
                            slot1_instr_q <= instr2;
                            slot1_pc_q    <= pc_q + FOUR;
                            pc_q          <= pc_q + EIGHT;
                            pair_cnt_q    <= pair_cnt_q + ONE;
                        end else begin
                            slot1_valid_q <= 1'b0;
                            pc_q          <= pc_q + FOUR;
                            single_cnt_q  <= single_cnt_q + ONE;
                        end
                    end
                end
                default: begin
                    slot0_valid_q <= 1'b0;
                    slot1_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign PC          = pc_q;
    assign PC4         = pc_q + FOUR;
    assign slot0_valid = slot0_valid_q;
    assign slot0_instr = slot0_instr_q;
    assign slot0_pc    = slot0_pc_q;
    assign slot1_valid = slot1_valid_q;
    assign slot1_instr = slot1_instr_q;
    assign slot1_pc    = slot1_pc_q;
    assign halted      = (state_q == ST_HALT);
    assign misalign    = misalign_q;
    assign pair_cnt    = pair_cnt_q;
    assign single_cnt  = single_cnt_q;

endmodule

// File: tb/tb_dual_issue_fetch_ctrl.sv
// Directed bench for dual_issue_fetch_ctrl: reset, pair/single issue, redirect, stall, halt, wrap, async reset.
module tb_dual_issue_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_en;
    logic [63:0] branch_pc;
    logic        stall;
    logic [31:0] instr1, instr2;
    logic [63:0] PC, PC4, slot0_pc, slot1_pc;
    logic        slot0_valid, slot1_valid, halted, misalign;
    logic [31:0] slot0_instr, slot1_instr, pair_cnt, single_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_X8  = 32'h00730433;
    localparam logic [31:0] SUB_X7  = 32'h404183B3;

    dual_issue_fetch_ctrl #(.XLEN(64), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .branch_en(branch_en), .branch_pc(branch_pc),
        .stall(stall), .instr1(instr1), .instr2(instr2),
        .PC(PC), .PC4(PC4),
        .slot0_valid(slot0_valid), .slot0_instr(slot0_instr), .slot0_pc(slot0_pc),
        .slot1_valid(slot1_valid), .slot1_instr(slot1_instr), .slot1_pc(slot1_pc),
        .halted(halted), .misalign(misalign), .pair_cnt(pair_cnt), .single_cnt(single_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch_en = 1'b0; branch_pc = '0; stall = 1'b0;
        instr1 = '0; instr2 = '0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        checks++; if (PC !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, 64'h0); end
        checks++; if (PC4 !== 64'h4) begin errors++; $display("FAIL reset_pc4: got %h want %h", PC4, 64'h4); end
        checks++; if ({slot0_valid, slot1_valid, halted, misalign} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {slot0_valid, slot1_valid, halted, misalign}); end
        checks++; if ({pair_cnt, single_cnt} !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", {pair_cnt, single_cnt}); end
    endtask

    task automatic test_pair_issue();
        instr1 = ADD_X8; instr2 = SUB_X7;
        step();
        checks++; if ({slot0_valid, slot1_valid} !== 2'b11) begin errors++; $display("FAIL pair_valid: got %b want 11", {slot0_valid, slot1_valid}); end
        checks++; if (slot0_pc !== 64'h0 || slot1_pc !== 64'h4) begin errors++; $display("FAIL pair_slot_pc: got %h/%h want 0/4", slot0_pc, slot1_pc); end
        checks++; if (slot0_instr !== ADD_X8 || slot1_instr !== SUB_X7) begin errors++; $display("FAIL pair_instr: got %h/%h want %h/%h", slot0_instr, slot1_instr, ADD_X8, SUB_X7); end
        checks++; if (PC !== 64'h8 || PC4 !== 64'hC) begin errors++; $display("FAIL pair_pc: got %h/%h want 8/c", PC, PC4); end
        checks++; if (pair_cnt !== 32'd1) begin errors++; $display("FAIL pair_cnt: got %0d want 1", pair_cnt); end
    endtask

    task automatic test_raw_split();
        instr1 = 32'h015A04B3; instr2 = 32'h00148493;
        step();
        checks++; if ({slot0_valid, slot1_valid} !== 2'b10) begin errors++; $display("FAIL raw_valid: got %b want 10", {slot0_valid, slot1_valid}); end
        checks++; if (slot0_pc !== 64'h8) begin errors++; $display("FAIL raw_slot0_pc: got %h want 8", slot0_pc); end
        checks++; if (slot1_instr !== SUB_X7 || slot1_pc !== 64'h4) begin errors++; $display("FAIL raw_slot1_hold: got %h/%h want %h/4", slot1_instr, slot1_pc, SUB_X7); end
        checks++; if (PC !== 64'hC || single_cnt !== 32'd1 || pair_cnt !== 32'd1) begin errors++; $display("FAIL raw_pc_cnt: got %h %0d %0d want c 1 1", PC, single_cnt, pair_cnt); end
    endtask

    task automatic test_other_splits();
        instr1 = 32'hF0953823; instr2 = 32'hF1053403;
        step();
        checks++; if (slot1_valid !== 1'b0 || PC !== 64'h10 || single_cnt !== 32'd2) begin errors++; $display("FAIL mem_split: got %b %h %0d want 0 10 2", slot1_valid, PC, single_cnt); end
        instr1 = 32'h02740463; instr2 = ADD_X8;
        step();
        checks++; if (slot1_valid !== 1'b0 || slot0_pc !== 64'h10 || PC !== 64'h14 || single_cnt !== 32'd3) begin errors++; $display("FAIL branch_split: got %b %h %h %0d want 0 10 14 3", slot1_valid, slot0_pc, PC, single_cnt); end
        instr1 = ADD_X8; instr2 = 32'h0;
        step();
        checks++; if (slot1_valid !== 1'b0 || PC !== 64'h18 || single_cnt !== 32'd4) begin errors++; $display("FAIL zero2_split: got %b %h %0d want 0 18 4", slot1_valid, PC, single_cnt); end
        instr1 = ADD_X8; instr2 = 32'h00100413;
        step();
        checks++; if (slot1_valid !== 1'b0 || PC !== 64'h1C || single_cnt !== 32'd5) begin errors++; $display("FAIL waw_split: got %b %h %0d want 0 1c 5", slot1_valid, PC, single_cnt); end
        instr1 = 32'h00000013; instr2 = 32'h00100093;
        step();
        checks++; if ({slot0_valid, slot1_valid} !== 2'b11 || slot1_pc !== 64'h20 || PC !== 64'h24 || pair_cnt !== 32'd2) begin errors++; $display("FAIL x0_pair: got %b %h %h %0d want 11 20 24 2", {slot0_valid, slot1_valid}, slot1_pc, PC, pair_cnt); end
    endtask

    task automatic test_redirect_stall();
        instr1 = ADD_X8; instr2 = SUB_X7;
        branch_en = 1'b1; stall = 1'b1; branch_pc = 64'h54;
        step();
        checks++; if (PC !== 64'h54 || PC4 !== 64'h58) begin errors++; $display("FAIL redir_pc: got %h/%h want 54/58", PC, PC4); end
        checks++; if ({slot0_valid, slot1_valid, misalign} !== 3'b000) begin errors++; $display("FAIL redir_flush: got %b want 000", {slot0_valid, slot1_valid, misalign}); end
        checks++; if (pair_cnt !== 32'd2 || single_cnt !== 32'd5) begin errors++; $display("FAIL redir_cnt: got %0d/%0d want 2/5", pair_cnt, single_cnt); end
        branch_pc = 64'h56;
        step();
        checks++; if (PC !== 64'h54 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_set: got %h %b want 54 1", PC, misalign); end
        branch_en = 1'b0; stall = 1'b0;
        step();
        checks++; if (PC !== 64'h5C || slot0_pc !== 64'h54 || pair_cnt !== 32'd3 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %h %h %0d %b want 5c 54 3 1", PC, slot0_pc, pair_cnt, misalign); end
    endtask

    task automatic test_stall_hold();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr1 = 32'h02740463 + i; instr2 = 32'h0;
            step();
            checks++; if (PC !== 64'h5C || {slot0_valid, slot1_valid} !== 2'b11 || slot0_pc !== 64'h54 || slot0_instr !== ADD_X8 || pair_cnt !== 32'd3 || single_cnt !== 32'd5) begin
                errors++; $display("FAIL stall_hold%0d: got %h %b %h %h %0d %0d want 5c 11 54 %h 3 5", i, PC, {slot0_valid, slot1_valid}, slot0_pc, slot0_instr, pair_cnt, single_cnt, ADD_X8);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_halt();
        instr1 = 32'h0; instr2 = ADD_X8;
        step();
        checks++; if (halted !== 1'b1 || {slot0_valid, slot1_valid} !== 2'b00 || PC !== 64'h5C) begin errors++; $display("FAIL halt_enter: got %b %b %h want 1 00 5c", halted, {slot0_valid, slot1_valid}, PC); end
        instr1 = ADD_X8; instr2 = SUB_X7;
        step();
        checks++; if (halted !== 1'b1 || slot0_valid !== 1'b0 || PC !== 64'h5C || pair_cnt !== 32'd3) begin errors++; $display("FAIL halt_stay: got %b %b %h %0d want 1 0 5c 3", halted, slot0_valid, PC, pair_cnt); end
        branch_en = 1'b1; branch_pc = 64'h0;
        step();
        checks++; if (halted !== 1'b0 || PC !== 64'h0 || slot0_valid !== 1'b0) begin errors++; $display("FAIL halt_exit: got %b %h %b want 0 0 0", halted, PC, slot0_valid); end
        branch_en = 1'b0;
        step();
        checks++; if ({slot0_valid, slot1_valid} !== 2'b11 || slot0_pc !== 64'h0 || PC !== 64'h8 || pair_cnt !== 32'd4) begin errors++; $display("FAIL resume: got %b %h %h %0d want 11 0 8 4", {slot0_valid, slot1_valid}, slot0_pc, PC, pair_cnt); end
    endtask

    task automatic test_wrap();
        branch_en = 1'b1; branch_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        checks++; if (PC !== 64'hFFFF_FFFF_FFFF_FFFC || PC4 !== 64'h0) begin errors++; $display("FAIL wrap_redir: got %h/%h want fffffffffffffffc/0", PC, PC4); end
        branch_en = 1'b0;
        step();
        checks++; if (PC !== 64'h4 || slot1_pc !== 64'h0 || slot0_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_pair: got %h %h %h want 4 0 fffffffffffffffc", PC, slot1_pc, slot0_pc); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({slot0_valid, slot1_valid, halted, misalign} !== 4'b0 || PC !== 64'h0 || PC4 !== 64'h4) begin errors++; $display("FAIL async_rst_flags: got %b %h %h want 0000 0 4", {slot0_valid, slot1_valid, halted, misalign}, PC, PC4); end
        checks++; if ({pair_cnt, single_cnt} !== 64'h0 || slot0_pc !== 64'h0 || slot1_instr !== 32'h0) begin errors++; $display("FAIL async_rst_data: got %h %h %h want 0 0 0", {pair_cnt, single_cnt}, slot0_pc, slot1_instr); end
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pair_issue();
        test_raw_split();
        test_other_splits();
        test_redirect_stall();
        test_stall_hold();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_issue_fetch_ctrl.md
Name: dual_issue_fetch_ctrl

Overview:
Fetch/issue sequencer for the 2-way superscalar core. It drives the PC and PC4 addresses into the dual-read instruction memory, then checks the returned instruction pair for intra-pair hazards. Each cycle it issues either both instructions or only the first. It also handles branch redirect, pipeline stall and an empty-memory halt, and keeps issue statistics for performance bring-up.

Parameters:
XLEN, 64, PC / address width
RESET_PC, 0, fetch address after reset
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
branch_en  input  1  redirect request from execute stage
branch_pc  input  XLEN  redirect target
stall  input  1  back-pressure from decode/hazard unit
instr1  input  32  instruction memory data at PC (combinational)
instr2  input  32  instruction memory data at PC4 (combinational)
PC  output  XLEN  fetch address, slot 0
PC4  output  XLEN  fetch address, slot 1 (always PC+4)
slot0_valid  output  1  slot 0 issued
slot0_instr  output  32  slot 0 instruction
slot0_pc  output  XLEN  slot 0 address
slot1_valid  output  1  slot 1 issued
slot1_instr  output  32  slot 1 instruction
slot1_pc  output  XLEN  slot 1 address
halted  output  1  FSM in HALT
misalign  output  1  sticky: a redirect target had bits [1:0] != 0
pair_cnt  output  CNT_W  cycles with both slots issued
single_cnt  output  CNT_W  cycles with only slot 0 issued

Behaviour:
- Reset (rst_n low, asynchronous):
  - PC=RESET_PC, PC4=RESET_PC+4.
  - All slot outputs and counters 0; misalign=0; halted=0.
  - FSM enters RUN.
- FSM states: RUN, HALT.
- Per-posedge priority: branch_en > stall > normal.
- branch_en=1, in either state:
  - PC=branch_pc with [1:0] forced to 0; PC4=that value+4.
  - Both slot valids cleared (flush); FSM goes to RUN.
  - misalign set if branch_pc[1:0]!=0.
  - stall is ignored in that cycle.
- stall=1, no branch: PC, PC4, all slot outputs, counters and state held unchanged.
- RUN, normal cycle:
  - If instr1==32'h0: FSM goes to HALT, both valids 0, PC held.
  - Else the hazard check runs on the instr1/instr2 pair, as below.
- Hazard check (split=1 if any condition holds):
  - instr1 writes a register (opcode 0110011, 0010011, 0000011, 1101111, 1100111) and rd1!=0, and:
    - instr2 reads rd1 as rs1 (any opcode except 1101111), or
    - instr2 reads rd1 as rs2 (opcodes 0110011, 0100011, 1100011), or
    - instr2 also writes rd1.
  - Both instructions are memory ops (opcode 0000011 or 0100011).
  - instr1 is a control op (1100011, 1101111, 1100111).
  - instr2==32'h0.
- split=0 (pair issue):
  - slot0 = {1, instr1, PC}; slot1 = {1, instr2, PC4}.
  - PC+=8, PC4+=8; pair_cnt++.
- split=1 (single issue):
  - slot0 = {1, instr1, PC}; slot1_valid=0, slot1_instr/pc keep their previous values.
  - PC+=4, PC4+=4; single_cnt++.
- HALT:
  - Valids 0, PC frozen.
  - Exits only on branch_en.
- Issue latency: the pair fetched at PC appears on the slot outputs one cycle later (registered).
- Arithmetic and widths:
  - PC arithmetic is modulo 2^XLEN and wraps at the top silently.
  - Counters wrap modulo 2^CNT_W.
  - Register fields: rd=[11:7], rs1=[19:15], rs2=[24:20].
- Reset asserted mid-operation discards all in-flight slots immediately, without waiting for a clock edge.

Test Plan:
- Reset, RESET_PC=0:
  - After rst_n rises: PC=0, PC4=4, valids 0.
  - With instr1=0x00730433 (ADD x8,x6,x7) and instr2=0x404183B3 (SUB x7): after next posedge both valids 1, slot0_pc=0, slot1_pc=4, PC=8, pair_cnt=1.
- RAW split:
  - instr1=0x015A04B3 (ADD x9,…) with instr2=0x00148493 (ADDI x9,x9,1) gives slot0_valid=1, slot1_valid=0, PC advances 4, single_cnt=1.
- Memory-pair split and branch-first split:
  - SD 0xF0953823 then LD 0xF1053403: single issue.
  - BEQ 0x02740463 in slot 0: single issue.
- Redirect with simultaneous stall:
  - branch_en=1, stall=1, branch_pc=0x54: next PC=0x54, PC4=0x58, valids 0.
  - branch_pc=0x56: PC=0x54, misalign=1, and it stays 1 afterwards.
- Stall hold, then HALT:
  - stall for 3 cycles: all outputs unchanged.
  - instr1=0 in RUN: halted=1, PC frozen.
  - branch_en to 0x0: halted=0 next cycle and fetch resumes.
- Async reset mid-stream: drop rst_n between edges; all outputs clear immediately, before the next posedge.
